prefix_hash: RTL and testbench
==============================

Name: prefix_hash

Overview:
- Hash unit between the FIB and its table index. The FIB presents a name prefix and its length; this block returns the 10-bit bucket index used for both FIB inserts and longest-prefix lookups.
- The FIB decrements the length and re-hashes on every lookup miss. The hash therefore covers only the first `len` prefix bits, so one prefix hashes differently at each length.
- Multi-cycle CRC over 8 bytes, with valid/ready handshakes on both sides.

Parameters:
- HASH_W, 10, output hash width (FIB table depth = 2**HASH_W).
- CRC_POLY, 10'h233, CRC-10 generator (x^10+x^9+x^5+x^4+x+1), implicit x^10 term.
- CRC_INIT, 10'h3FF, CRC register seed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  prefix/len request valid.
- in_ready  out  1  block can accept a request.
- in_prefix  in  64  name prefix, MSB = first name bit.
- in_len  in  6  number of significant prefix bits, 0..63.
- out_valid  out  1  hash result valid.
- out_ready  in  1  consumer takes result.
- out_hash  out  HASH_W  bucket index.
- out_len  out  6  echo of the latched len, for consumer tagging.

Behaviour:
- Reset (rst=0, async): state=IDLE, in_ready=1, out_valid=0, out_hash=0, out_len=0, byte counter=0, CRC register=CRC_INIT.
- States: IDLE, CALC, DONE.
- IDLE
  - in_ready=1.
  - On an edge with in_valid=1: latch masked prefix and len, CRC register <= CRC_INIT, byte counter <= 0, go to CALC.
  - Mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> in_len). len=0 gives an all-zero prefix. Bit 0 is always masked because max len is 63.
- CALC
  - in_ready=0; in_valid is ignored and the request is not queued.
  - Each edge folds one byte into the CRC, MSB-first, bytes [63:56] down to [7:0]. This is a byte-wise parallel CRC step (8 serial shift iterations unrolled combinationally). Counter increments.
  - On the edge processing byte 7: out_hash <= final CRC ^ {{(HASH_W-6){1'b0}}, len}, out_len <= len, out_valid <= 1, go to DONE.
- DONE
  - out_valid=1; out_hash and out_len are held stable until the handshake.
  - On an edge with out_ready=1: out_valid <= 0, go to IDLE.
  - No back-to-back acceptance in DONE; in_ready stays 0.
- Latency: accept edge T0; out_valid visible after edge T8 (8 cycles).
- Throughput: one request per 10 cycles minimum (accept, 8 CALC, handshake).
- out_ready asserted before out_valid has no effect.
- Determinism: equal (masked prefix, len) pairs always produce equal out_hash. Prefixes differing only below bit position 63-len+1 produce equal hashes.
- Reset mid-CALC or mid-DONE: immediate return to reset values; the in-flight request is dropped and out_valid falls asynchronously.
- in_prefix/in_len may change freely after the accept edge; only latched copies are used.

Decomposition:
- Shared package ndn_pkg:
  - PREFIX_W=64, LEN_W=6, HASH_W=10
  - CRC_POLY, CRC_INIT
  - state encoding (IDLE/CALC/DONE)
  - function crc10_byte(crc, byte) for the single-byte CRC step, also used by the bench golden model.
- One natural sub-module: prefix_mask (combinational len-to-64-bit mask and apply). Keep it in this file or make it a package function; no further hierarchy.

Test Plan:
- Single hash: prefix=64'hDEAD_BEEF_0123_4567, len=32, out_ready=1 -> in_ready drops next cycle; out_valid rises exactly 8 cycles after accept; out_hash = golden crc10 over bytes DE,AD,BE,EF,00,00,00,00, then ^32; out_len=32.
- Masking and len sensitivity:
  - prefix=64'hDEAD_BEEF_FFFF_FFFF, len=32 -> same out_hash as the single-hash scenario.
  - Same prefix with len=31 -> golden value; differs from the len=32 result.
  - len=0 with any prefix -> golden(all-zero bytes) ^ 0.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid/out_hash/out_len stable; in_valid pulsed meanwhile is ignored (in_ready=0); result retires on the first out_ready=1 edge, then in_ready=1.
- FIB miss walk: issue len=40,39,38,37 for one prefix back-to-back -> four results in order, each matching golden, spaced ≥10 cycles.
- Reset mid-operation: assert rst=0 at CALC byte 4 -> out_valid=0 and in_ready=1 immediately. A new request after release gives a correct golden hash with no residue from the aborted one.
- Random: 1000 random (prefix, len) pairs with random out_ready stalls -> every out_hash equals the golden model; no lost or duplicated results.

Source files
------------

// File: rtl/ndn_pkg.sv
// rtl/ndn_pkg.sv - shared widths, CRC-10 constants, FSM encoding and byte CRC step
package ndn_pkg;

    localparam int PREFIX_W = 64;
    localparam int LEN_W    = 6;
    localparam int HASH_W   = 10;

    localparam logic [HASH_W-1:0] CRC_POLY = 10'h233;
    localparam logic [HASH_W-1:0] CRC_INIT = 10'h3FF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One byte folded MSB-first: eight serial shift steps unrolled.
    function automatic logic [HASH_W-1:0] crc10_byte(input logic [HASH_W-1:0] crc,
                                                     input logic [7:0]        data);
        logic [HASH_W-1:0] c;
        logic              fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[HASH_W-1] ^ data[i];
            c  = {c[HASH_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/prefix_mask.sv
// rtl/prefix_mask.sv - keeps only the first len bits of a prefix (MSB = first name bit)
module prefix_mask
    import ndn_pkg::*;
(
    input  logic [PREFIX_W-1:0] prefix_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic [PREFIX_W-1:0] masked_o
);

    assign masked_o = prefix_i & ~({PREFIX_W{1'b1}} >> len_i);

endmodule

// File: rtl/prefix_hash.sv
// rtl/prefix_hash.sv - multi-cycle CRC-10 bucket hash of a length-masked name prefix
module prefix_hash
    import ndn_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PREFIX_W-1:0] in_prefix,
    input  logic [LEN_W-1:0]    in_len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [HASH_W-1:0]   out_hash,
    output logic [LEN_W-1:0]    out_len
);

    state_e              state_q, state_d;
    logic [PREFIX_W-1:0] prefix_q, prefix_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [HASH_W-1:0]   crc_q, crc_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [HASH_W-1:0]   hash_q, hash_d;
    logic [LEN_W-1:0]    olen_q, olen_d;
    logic [PREFIX_W-1:0] masked;
    logic [HASH_W-1:0]   crc_step;

    prefix_mask u_mask (
        .prefix_i (in_prefix),
        .len_i    (in_len),
        .masked_o (masked)
    );

    // The working prefix shifts left each CALC cycle, so the next byte is always [63:56].
    assign crc_step = crc10_byte(crc_q, prefix_q[PREFIX_W-1 -: 8]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            prefix_q <= '0;
            len_q    <= '0;
            crc_q    <= CRC_INIT;
            cnt_q    <= '0;
            hash_q   <= '0;
            olen_q   <= '0;
        end else begin
            state_q  <= state_d;
            prefix_q <= prefix_d;
            len_q    <= len_d;
            crc_q    <= crc_d;
            cnt_q    <= cnt_d;
            hash_q   <= hash_d;
            olen_q   <= olen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prefix_d = prefix_q;
        len_d    = len_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        hash_d   = hash_q;
        olen_d   = olen_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    prefix_d = masked;
                    len_d    = in_len;
                    crc_d    = CRC_INIT;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                crc_d    = crc_step;
                prefix_d = {prefix_q[PREFIX_W-9:0], 8'h00};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    hash_d  = crc_step ^ {{(HASH_W-LEN_W){1'b0}}, len_q};
                    olen_d  = len_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake flags decode straight from state so reset drops out_valid asynchronously.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_hash  = hash_q;
    assign out_len   = olen_q;

endmodule

// File: tb/tb_prefix_hash.sv
// tb/tb_prefix_hash.sv - scoreboard bench for prefix_hash against a bit-serial golden model
module tb_prefix_hash;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_prefix = '0;
    logic [5:0]  in_len = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_hash;
    logic [5:0]  out_len;

    typedef struct packed {
        logic [9:0] hash;
        logic [5:0] len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   results = 0;
    int   cyc = 0;
    int   last_accept = 0;
    int   or_mode = 0;
    logic prev_valid = 1'b0;

    prefix_hash dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prefix (in_prefix),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hash  (out_hash),
        .out_len   (out_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    function automatic logic [9:0] golden(input logic [63:0] p, input logic [5:0] l);
        logic [63:0] mp;
        logic [9:0]  crc;
        logic        fb;
        mp = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < int'(l)) mp[63-i] = p[63-i];
        end
        crc = 10'h3FF;
        for (int i = 63; i >= 0; i--) begin
            fb  = crc[9] ^ mp[i];
            crc = {crc[8:0], 1'b0};
            if (fb) crc = crc ^ 10'h233;
        end
        return crc ^ {4'b0, l};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compare every handshake against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst && out_valid && !prev_valid)
            check("latency", 64'(cyc - last_accept), 64'd8);
        prev_valid = out_valid;
        if (rst && out_valid && out_ready) begin
            results++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_hash", 64'(out_hash), 64'(e.hash));
                check("out_len", 64'(out_len), 64'(e.len));
            end
        end
    end

    task automatic issue(input logic [63:0] p, input logic [5:0] l);
        bit done;
        done = 0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_prefix = p;
        in_len    = l;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{hash: golden(p, l), len: l});
                @(posedge clk); #1;
                last_accept = cyc;
                in_valid  = 1'b0;
                in_prefix = $urandom();
                in_len    = 6'($urandom());
                check("in_ready_drop", 64'(in_ready), 64'd0);
                done = 1;
            end
        end
        if (!done) begin
            in_valid = 1'b0;
            check("accept_timeout", 64'd1, 64'd0);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [9:0] h0;
        logic [5:0] l0;
        bit         stable;
        bit         seen;
        int         n0;

        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_hash", 64'(out_hash), 64'd0);
        check("rst_out_len", 64'(out_len), 64'd0);
        @(negedge clk); rst = 1'b1;

        or_mode = 1;
        issue(64'hDEAD_BEEF_0123_4567, 6'd32);
        drain();
        issue(64'hDEAD_BEEF_FFFF_FFFF, 6'd32);
        issue(64'hDEAD_BEEF_FFFF_FFFF, 6'd31);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 6'd0);
        issue(64'h1234_5678_9ABC_DEF0, 6'd63);
        issue(64'h8000_0000_0000_0000, 6'd1);
        drain();

        // Backpressure: hold result for 20 cycles while poking in_valid.
        or_mode = 0;
        @(posedge clk); #2;
        issue(64'hCAFE_F00D_1357_9BDF, 6'd45);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("bp_valid_seen", 64'(seen), 64'd1);
        h0 = out_hash; l0 = out_len; stable = 1; n0 = results;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            in_valid = k[0]; in_prefix = 64'h0F0F_0F0F_0F0F_0F0F; in_len = 6'd20;
            @(negedge clk);
            if (!out_valid || out_hash !== h0 || out_len !== l0 || in_ready) stable = 0;
        end
        @(posedge clk); #1; in_valid = 1'b0;
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_no_retire", 64'(results - n0), 64'd0);
        or_mode = 1;
        drain();
        @(negedge clk);
        check("bp_in_ready_after", 64'(in_ready), 64'd1);
        check("bp_valid_after", 64'(out_valid), 64'd0);

        // FIB miss walk.
        for (int l = 40; l >= 37; l--) issue(64'hA5A5_5A5A_C3C3_3C3C, 6'(l));
        drain();

        // Reset while processing byte 4.
        issue(64'h0123_4567_89AB_CDEF, 6'd50);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_hash", 64'(out_hash), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(64'hFEDC_BA98_7654_3210, 6'd17);
        drain();

        // Random pairs with random output stalls.
        or_mode = 2;
        n0 = results;
        for (int i = 0; i < 1000; i++) issue({$urandom(), $urandom()}, 6'($urandom_range(0, 63)));
        drain();
        check("rand_count", 64'(results - n0), 64'd1000);
        or_mode = 1;
        repeat (3) @(negedge clk);
        check("final_idle", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
